// File: rtl/adc_pkg.sv
// Shared types, default widths and width helpers for the ADC capture engine.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } cap_state_e;

    localparam int unsigned NCH_DEF    = 3;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned BANKS_DEF  = 4;

    // Linear pointer width: per-bank address bits plus bank-select bits.
    function automatic int unsigned ptr_width(int unsigned addr_w, int unsigned banks);
        return addr_w + $clog2(banks);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; priority moves to granted+1.
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] prio_q, prio_d;

    // Search requests starting at the priority pointer, wrapping at N.
    always_comb begin
        int unsigned j;
        logic [IDX_W-1:0] jj;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j  = (32'(prio_q) + i) % N;
            jj = IDX_W'(j);
            if (!valid_o && req_i[jj]) begin
                valid_o   = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

    // Next priority: one past the winner, wrapping at N.
    always_comb begin
        prio_d = prio_q;
        if (valid_o) begin
            prio_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + IDX_W'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// N-channel ADC capture engine: per-channel hold registers, round-robin
// arbitration and a registered write port into a linear banked SRAM buffer.
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned NCH    = NCH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BANKS  = BANKS_DEF,
    localparam int unsigned PTR_W  = ptr_width(ADDR_W, BANKS),
    localparam int unsigned MASK_W = DATA_W / 8,
    localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  circ_i,
    input  logic [NCH-1:0]        ch_en_i,
    input  logic [PTR_W-1:0]      length_i,
    input  logic [NCH-1:0]        adc_dvalid_i,
    input  logic [NCH*DATA_W-1:0] adc_dat_i,
    output logic [BANKS-1:0]      mem_wenb_o,
    output logic [ADDR_W-1:0]     mem_waddr_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic [MASK_W-1:0]     wmask_o,
    output logic [PTR_W-1:0]      wr_ptr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wrapped_o,
    output logic [NCH-1:0]        overflow_o,
    output logic                  irq_o
);

    cap_state_e state_q, state_d;

    logic              circ_q;
    logic [NCH-1:0]    ch_en_q;
    logic [PTR_W-1:0]  last_ptr_q;  // length-1; length 0 wraps to all ones = full buffer
    logic [PTR_W-1:0]  wr_ptr_q;
    logic              done_q, wrapped_q, irq_q;
    logic [NCH-1:0]    overflow_q, overflow_d;
    logic [NCH-1:0]    hold_full_q, hold_full_d, hold_load;
    logic [DATA_W-1:0] hold_q [NCH];

    logic [NCH-1:0]    arb_req, arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;

    logic start_acc, wr_en, last_wr, cap_end;

    assign arb_req = hold_full_q & {NCH{busy_o}};

    rr_arbiter #(
        .N (NCH)
    ) u_arb (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .req_i   (arb_req),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Write qualification: a grant is a write; detect the final one-shot write.
    always_comb begin
        start_acc = start_i && (state_q != CAPTURE);
        wr_en     = arb_valid;
        last_wr   = wr_en && !circ_q && (wr_ptr_q == last_ptr_q);
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start_i) state_d = CAPTURE;
            CAPTURE:    if (stop_i || last_wr) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o  = (state_q == CAPTURE);
        cap_end = busy_o && (stop_i || last_wr);
    end

    // Hold-register next state and overflow detection.
    always_comb begin
        hold_load   = '0;
        hold_full_d = hold_full_q;
        overflow_d  = overflow_q;
        if (start_acc) overflow_d = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (arb_gnt[c]) hold_full_d[c] = 1'b0;
            if (busy_o && ch_en_q[c] && adc_dvalid_i[c]) begin
                // A grant this cycle frees the slot, so the new sample still fits.
                if (!hold_full_q[c] || arb_gnt[c]) begin
                    hold_load[c]   = 1'b1;
                    hold_full_d[c] = 1'b1;
                end else begin
                    overflow_d[c] = 1'b1;
                end
            end
        end
        // Leaving CAPTURE discards anything still held.
        if (cap_end) hold_full_d = '0;
    end

    // Hold registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            hold_full_q <= '0;
            for (int unsigned c = 0; c < NCH; c++) hold_q[c] <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (hold_load[c]) hold_q[c] <= adc_dat_i[c*DATA_W +: DATA_W];
            end
        end
    end

    // Capture configuration, linear pointer and sticky status flags.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            circ_q     <= 1'b0;
            ch_en_q    <= '0;
            last_ptr_q <= '0;
            wr_ptr_q   <= '0;
            done_q     <= 1'b0;
            wrapped_q  <= 1'b0;
            irq_q      <= 1'b0;
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            irq_q      <= cap_end;
            if (start_acc) begin
                circ_q     <= circ_i;
                ch_en_q    <= ch_en_i;
                last_ptr_q <= length_i - PTR_W'(1);
                wr_ptr_q   <= '0;
                done_q     <= 1'b0;
                wrapped_q  <= 1'b0;
            end else if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (circ_q && (wr_ptr_q == '1)) wrapped_q <= 1'b1;
            end
            if (cap_end) done_q <= 1'b1;
        end
    end

    // Registered SRAM write port; only the addressed bank is strobed.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mem_wenb_o  <= '1;
            mem_waddr_o <= '0;
            mem_data_o  <= '0;
            wmask_o     <= '0;
        end else if (wr_en) begin
            mem_wenb_o  <= ~(BANKS'(1) << wr_ptr_q[PTR_W-1:ADDR_W]);
            mem_waddr_o <= wr_ptr_q[ADDR_W-1:0];
            mem_data_o  <= hold_q[arb_idx];
            wmask_o     <= '1;
        end else begin
            mem_wenb_o <= '1;
            wmask_o    <= '0;
        end
    end

    assign wr_ptr_o   = wr_ptr_q;
    assign done_o     = done_q;
    assign wrapped_o  = wrapped_q;
    assign overflow_o = overflow_q;
    assign irq_o      = irq_q;

endmodule
